// File: rtl/bfp_dot4_adder_tree.sv
// bfp_dot4_adder_tree
// Block-floating-point 4-element dot product. Vector A (in1..in4, shared exp1)
// is multiplied element-wise with vector B (in5..in8, shared exp2), and the four
// products are summed by a 2-level adder tree. The full-precision signed sum
// and the carry-preserving exponent sum are emitted without rounding or bias
// handling; the downstream normaliser owns both.
//
// Build option macro: ADDER_TREE_PIPE_EN
//   defined   : 3 register stages (products | partial sums | final sum), latency 3
//   undefined : combinational products and tree, one output register, latency 1
// The arithmetic is identical in both builds. The widths are exact for every
// input, so the sum cannot overflow, wrap or saturate.

module bfp_dot4_adder_tree #(
  parameter int SignFrac_size = 11,
  parameter int exp_size      = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [SignFrac_size-1:0]       in1,
  input  logic [SignFrac_size-1:0]       in2,
  input  logic [SignFrac_size-1:0]       in3,
  input  logic [SignFrac_size-1:0]       in4,
  input  logic [SignFrac_size-1:0]       in5,
  input  logic [SignFrac_size-1:0]       in6,
  input  logic [SignFrac_size-1:0]       in7,
  input  logic [SignFrac_size-1:0]       in8,
  input  logic [exp_size-1:0]            exp1,
  input  logic [exp_size-1:0]            exp2,
  output logic signed [2*SignFrac_size+1:0] result,
  output logic [exp_size:0]              result_exp,
  output logic                           out_valid
);

  localparam int S  = SignFrac_size;
  localparam int PW = 2 * S;       // product width
  localparam int SW = 2 * S + 1;   // partial-sum width
  localparam int RW = 2 * S + 2;   // final-sum width
  localparam int EW = exp_size + 1;

  // Exact signed product: sign-extend both operands to PW bits. The low PW
  // bits of the unsigned product then equal the two's complement product.
  function automatic logic [PW-1:0] smul(input logic [S-1:0] a, input logic [S-1:0] b);
    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;
    a_ext = {{S{a[S-1]}}, a};
    b_ext = {{S{b[S-1]}}, b};
    return a_ext * b_ext;
  endfunction

  // First tree level: two PW-bit signed products into one SW-bit sum.
  function automatic logic [SW-1:0] add_lvl1(input logic [PW-1:0] a, input logic [PW-1:0] b);
    return {a[PW-1], a} + {b[PW-1], b};
  endfunction

  // Second tree level: two SW-bit signed partial sums into one RW-bit sum.
  function automatic logic [RW-1:0] add_lvl2(input logic [SW-1:0] a, input logic [SW-1:0] b);
    return {a[SW-1], a} + {b[SW-1], b};
  endfunction

  // Output register stage (shared by both builds)
  logic [RW-1:0] res_d, res_q;
  logic [EW-1:0] rexp_d, rexp_q;
  logic          vld_d, vld_q;

`ifdef ADDER_TREE_PIPE_EN

  // Stage 1: products, exponent sum, valid
  logic [PW-1:0] p1_d, p2_d, p3_d, p4_d;
  logic [PW-1:0] p1_q, p2_q, p3_q, p4_q;
  logic [EW-1:0] e1_d, e1_q;
  logic          v1_d, v1_q;
  // Stage 2: partial sums
  logic [SW-1:0] s0_d, s1_d, s0_q, s1_q;
  logic [EW-1:0] e2_q;
  logic          v2_q;

  // Stage-1 next state: element-wise products and combined exponent
  always_comb begin
    p1_d = smul(in1, in5);
    p2_d = smul(in2, in6);
    p3_d = smul(in3, in7);
    p4_d = smul(in4, in8);
    e1_d = {1'b0, exp1} + {1'b0, exp2};
    v1_d = in_valid;
  end

  // Stage-1 registers: load every cycle, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_q <= {PW{1'b0}};
      p2_q <= {PW{1'b0}};
      p3_q <= {PW{1'b0}};
      p4_q <= {PW{1'b0}};
      e1_q <= {EW{1'b0}};
      v1_q <= 1'b0;
    end else begin
      p1_q <= p1_d;
      p2_q <= p2_d;
      p3_q <= p3_d;
      p4_q <= p4_d;
      e1_q <= e1_d;
      v1_q <= v1_d;
    end
  end

  // Stage-2 next state: first adder-tree level
  always_comb begin
    s0_d = add_lvl1(p1_q, p2_q);
    s1_d = add_lvl1(p3_q, p4_q);
  end

  // Stage-2 registers: partial sums with exponent and valid alongside
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q <= {SW{1'b0}};
      s1_q <= {SW{1'b0}};
      e2_q <= {EW{1'b0}};
      v2_q <= 1'b0;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
      e2_q <= e1_q;
      v2_q <= v1_q;
    end
  end

  // Stage-3 next state: final adder-tree level
  always_comb begin
    res_d  = add_lvl2(s0_q, s1_q);
    rexp_d = e2_q;
    vld_d  = v2_q;
  end

`else

  logic [SW-1:0] s0_s, s1_s;

  // Single-cycle datapath: products and both tree levels in one combinational step
  always_comb begin
    s0_s   = add_lvl1(smul(in1, in5), smul(in2, in6));
    s1_s   = add_lvl1(smul(in3, in7), smul(in4, in8));
    res_d  = add_lvl2(s0_s, s1_s);
    rexp_d = {1'b0, exp1} + {1'b0, exp2};
    vld_d  = in_valid;
  end

`endif

  // Output registers: final sum, exponent and valid, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q  <= {RW{1'b0}};
      rexp_q <= {EW{1'b0}};
      vld_q  <= 1'b0;
    end else begin
      res_q  <= res_d;
      rexp_q <= rexp_d;
      vld_q  <= vld_d;
    end
  end

  assign result     = $signed(res_q);
  assign result_exp = rexp_q;
  assign out_valid  = vld_q;

endmodule

// File: tb/tb_bfp_dot4_adder_tree.sv
// Directed testbench for bfp_dot4_adder_tree (S=11, E=5).
// Latency follows the ADDER_TREE_PIPE_EN build option: 3 when defined, 1 otherwise.

module tb_bfp_dot4_adder_tree;

`ifdef ADDER_TREE_PIPE_EN
  localparam int L = 3;
`else
  localparam int L = 1;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [10:0] in1, in2, in3, in4, in5, in6, in7, in8;
  logic [4:0]  exp1, exp2;
  logic [23:0] result;
  logic [5:0]  result_exp;
  logic        out_valid;

  int checks   = 0;
  int failures = 0;

  bfp_dot4_adder_tree #(.SignFrac_size(11), .exp_size(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .in5(in5), .in6(in6), .in7(in7), .in8(in8),
    .exp1(exp1), .exp2(exp2),
    .result(result), .result_exp(result_exp), .out_valid(out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp_v);
    end
  endtask

  task automatic drive(input int a1, input int a2, input int a3, input int a4,
                       input int b1, input int b2, input int b3, input int b4,
                       input int e1, input int e2, input logic v);
    in1 = a1[10:0]; in2 = a2[10:0]; in3 = a3[10:0]; in4 = a4[10:0];
    in5 = b1[10:0]; in6 = b2[10:0]; in7 = b3[10:0]; in8 = b4[10:0];
    exp1 = e1[4:0]; exp2 = e2[4:0];
    in_valid = v;
  endtask

  // One isolated vector: drive at a falling edge, sample L cycles later, then
  // confirm the valid bit drops on the following cycle.
  task automatic run_one(input string tag,
                         input int a1, input int a2, input int a3, input int a4,
                         input int b1, input int b2, input int b3, input int b4,
                         input int e1, input int e2,
                         input logic [23:0] exp_res, input logic [5:0] exp_e);
    drive(a1, a2, a3, a4, b1, b2, b3, b4, e1, e2, 1'b1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    repeat (L - 1) @(negedge clk);
    check_val({tag, "_result"}, {8'h00, result}, {8'h00, exp_res});
    check_val({tag, "_exp"}, {26'h0, result_exp}, {26'h0, exp_e});
    check_val({tag, "_valid"}, {31'h0, out_valid}, 32'd1);
    @(negedge clk);
    check_val({tag, "_valid_drop"}, {31'h0, out_valid}, 32'd0);
  endtask

  // Streaming vectors and their hand-computed results
  int sa [4][8] = '{
    '{1, 2, 3, 4, 5, 6, 7, 8},
    '{-1, -2, -3, -4, 5, 6, 7, 8},
    '{100, 0, 0, 0, 100, 0, 0, 0},
    '{1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023}
  };
  int se [4][2] = '{'{1, 2}, '{10, 20}, '{16, 16}, '{31, 0}};
  logic [23:0] sres [4] = '{24'h000046, 24'hFFFFBA, 24'h002710, 24'h3FE004};
  logic [5:0]  sexp [4] = '{6'd3, 6'd30, 6'd32, 6'd31};

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    check_val("reset_result", {8'h00, result}, 32'd0);
    check_val("reset_exp", {26'h0, result_exp}, 32'd0);
    check_val("reset_valid", {31'h0, out_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Mixed positives: 440 + 2024 + 346 + 318096 = 320906
    run_one("mixed", 88, 184, 346, 564, 5, 11, 1, 564, 5, 18, 24'h04E58A, 6'd23);
    // (-1024)^2 * 4 = +4194304
    run_one("max_pos", -1024, -1024, -1024, -1024, -1024, -1024, -1024, -1024,
            3, 4, 24'h400000, 6'd7);
    // -1024 * 1023 * 4 = -4190208
    run_one("max_neg", -1024, -1024, -1024, -1024, 1023, 1023, 1023, 1023,
            0, 1, 24'hC01000, 6'd1);
    // Exponent carry kept: 31+31 = 62; result 1*(-1) = -1
    run_one("exp_carry", 1, 0, 0, 0, -1, 0, 0, 0, 31, 31, 24'hFFFFFF, 6'd62);
    // Exponent zero: 2*3 = 6
    run_one("exp_zero", 0, 2, 0, 0, 0, 3, 0, 0, 0, 0, 24'h000006, 6'd0);

    // Streaming: 4 back-to-back vectors, then idle; vector k appears at cycle k+L
    for (int c = 0; c <= 4 + L; c++) begin
      int k;
      k = c - L;
      if (k >= 0 && k < 4) begin
        check_val($sformatf("stream%0d_result", k), {8'h00, result}, {8'h00, sres[k]});
        check_val($sformatf("stream%0d_exp", k), {26'h0, result_exp}, {26'h0, sexp[k]});
        check_val($sformatf("stream%0d_valid", k), {31'h0, out_valid}, 32'd1);
      end else if (c >= L) begin
        check_val($sformatf("stream_idle_c%0d", c), {31'h0, out_valid}, 32'd0);
      end
      if (c < 4)
        drive(sa[c][0], sa[c][1], sa[c][2], sa[c][3], sa[c][4], sa[c][5], sa[c][6], sa[c][7],
              se[c][0], se[c][1], 1'b1);
      else
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
      @(negedge clk);
    end

    // Reset mid-flight: fill the pipeline with valid vectors, then assert rst between edges
    drive(100, 0, 0, 0, 100, 0, 0, 0, 16, 16, 1'b1);
    repeat (L) @(negedge clk);
    check_val("prerst_valid", {31'h0, out_valid}, 32'd1);
    check_val("prerst_result", {8'h00, result}, 32'd10000);
    #2 rst = 1'b1;
    #1;
    check_val("asyncrst_result", {8'h00, result}, 32'd0);
    check_val("asyncrst_exp", {26'h0, result_exp}, 32'd0);
    check_val("asyncrst_valid", {31'h0, out_valid}, 32'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    rst = 1'b0;
    for (int c = 0; c < L + 1; c++) begin
      @(negedge clk);
      check_val($sformatf("postrst_stale_c%0d", c), {31'h0, out_valid}, 32'd0);
    end
    // Recovery after reset release
    run_one("postrst", 1, 2, 3, 4, 5, 6, 7, 8, 1, 2, 24'h000046, 6'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
